// File: rtl/regfile_wb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
//   Shared types and constants for the register-file writeback arbiter and
//   its busy scoreboard.
//   - REG_ADDR_W / REG_DATA_W : default register index / data widths
//   - reg_addr_t / reg_data_t : register index and data types at those widths
//   - REG_X0                  : index of the hard-wired zero register
//   - wb_req_t                : one writeback request {valid, rd, data}
//   - gnt_e                   : arbitration result / round-robin pointer
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    localparam reg_addr_t REG_X0 = '0;

    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        reg_data_t data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_REQ0 = 2'd1,
        GNT_REQ1 = 2'd2
    } gnt_e;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard
//   Per-register busy scoreboard. A bit is set when ID accepts an instruction
//   that will write that register and cleared when its writeback is granted.
//   ID is stalled while any of its operands or its destination is pending.
// Ports
//   clk, rst      clock, synchronous active-high reset
//   issue_valid   ID presents an instruction
//   issue_rs1/2   source registers
//   issue_rd      destination register (0 = no writeback)
//   issue_stall   combinational: instruction not accepted this cycle
//   clr_valid     a writeback is granted this cycle
//   clr_rd        destination of the granted writeback
//   busy          busy vector; bit 0 is always 0
// ----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int ADDR_W = REG_ADDR_W,
    localparam int NREG   = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rs1,
    input  logic [ADDR_W-1:0] issue_rs2,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_stall,
    input  logic              clr_valid,
    input  logic [ADDR_W-1:0] clr_rd,
    output logic [NREG-1:0]   busy
);

    logic [NREG-1:0] busy_p1;
    logic [NREG-1:0] busy_nxt;
    logic            hit_rs1;
    logic            hit_rs2;
    logic            hit_rd;
    logic            accept;

    // x0 never carries a hazard, whatever the busy vector says
    assign hit_rs1 = (issue_rs1 != '0) && busy_p1[issue_rs1];
    assign hit_rs2 = (issue_rs2 != '0) && busy_p1[issue_rs2];
    assign hit_rd  = (issue_rd  != '0) && busy_p1[issue_rd];

    assign issue_stall = issue_valid & (hit_rs1 | hit_rs2 | hit_rd);
    assign accept      = issue_valid & ~issue_stall & (issue_rd != '0);

    // Clear first, then set: a same-edge set of the same register wins.
    // No bypass: a cleared bit is only visible to ID from the next cycle.
    always_comb begin
        busy_nxt = busy_p1;
        if (clr_valid) begin
            busy_nxt[clr_rd] = 1'b0;
        end
        if (accept) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // ---- stage p1: scoreboard state ----
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_p1 <= '0;
        end else begin
            busy_p1 <= busy_nxt;
        end
    end

    assign busy = busy_p1;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Write-port controller for the ID-stage register file. Shares the single
//   write port between the ALU writeback (req0) and the load unit (req1),
//   drives RegWrite/WriteRegister/WriteData from a register stage, and keeps
//   a busy scoreboard that stalls ID on RAW/WAW hazards.
//
//   Build option REGARB_RR_EN:
//     undefined : fixed priority, req1 (load) over req0 (ALU); req0 may starve
//     defined   : round-robin on contention; the loser of a contested cycle
//                 wins the next contested cycle
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   issue_valid/rs1/rs2/rd    instruction presented by ID
//   issue_stall               combinational: instruction not accepted
//   req0_valid/rd/data        ALU writeback request
//   req0_ready                combinational grant for req0
//   req1_valid/rd/data        load writeback request
//   req1_ready                combinational grant for req1
//   rf_we/rf_waddr/rf_wdata   registered write port to the register file
//   busy                      scoreboard, bit i = write to register i pending
// ----------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter  int ADDR_W = REG_ADDR_W,
    parameter  int DATA_W = REG_DATA_W,
    localparam int NREG   = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rs1,
    input  logic [ADDR_W-1:0] issue_rs2,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_stall,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [NREG-1:0]   busy
);

    gnt_e              gnt_sel;
    logic              contested;
    logic              gnt_any;
    logic [ADDR_W-1:0] win_rd;
    logic [DATA_W-1:0] win_data;

    logic              vld_p1;
    logic [ADDR_W-1:0] waddr_p1;
    logic [DATA_W-1:0] wdata_p1;

    assign contested = req0_valid & req1_valid;

`ifdef REGARB_RR_EN
    // Winner of the most recent contested cycle; starts at req0 so the
    // first contest after reset goes to the load unit.
    gnt_e last_win_p1;

    always_comb begin
        gnt_sel = GNT_NONE;
        if (!rst) begin
            if (contested) begin
                gnt_sel = (last_win_p1 == GNT_REQ1) ? GNT_REQ0 : GNT_REQ1;
            end else if (req1_valid) begin
                gnt_sel = GNT_REQ1;
            end else if (req0_valid) begin
                gnt_sel = GNT_REQ0;
            end
        end
    end

    // ---- stage p1: round-robin pointer, moves only on contested grants ----
    always_ff @(posedge clk) begin
        if (rst) begin
            last_win_p1 <= GNT_REQ0;
        end else if (contested) begin
            last_win_p1 <= gnt_sel;
        end
    end
`else
    always_comb begin
        gnt_sel = GNT_NONE;
        if (!rst) begin
            if (req1_valid) begin
                gnt_sel = GNT_REQ1;
            end else if (req0_valid) begin
                gnt_sel = GNT_REQ0;
            end
        end
    end
`endif

    assign req0_ready = (gnt_sel == GNT_REQ0);
    assign req1_ready = (gnt_sel == GNT_REQ1);
    assign gnt_any    = (gnt_sel != GNT_NONE);

    always_comb begin
        win_rd   = req0_rd;
        win_data = req0_data;
        if (gnt_sel == GNT_REQ1) begin
            win_rd   = req1_rd;
            win_data = req1_data;
        end
    end

    // ---- stage p1: register-file write port ----
    // A grant to x0 completes the handshake but never raises the write enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
        end else begin
            vld_p1 <= gnt_any && (win_rd != '0);
            if (gnt_any) begin
                waddr_p1 <= win_rd;
                wdata_p1 <= win_data;
            end
        end
    end

    assign rf_we    = vld_p1;
    assign rf_waddr = waddr_p1;
    assign rf_wdata = wdata_p1;

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_rd    (issue_rd),
        .issue_stall (issue_stall),
        .clr_valid   (gnt_any),
        .clr_rd      (win_rd),
        .busy        (busy)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//   Directed vector table, a contention sequence and a randomized run checked
//   against a behavioural model of the write-port arbiter and scoreboard.
// ----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

`ifdef REGARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_stall;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_rd, req1_rd;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_rd    (issue_rd),
        .issue_stall (issue_stall),
        .req0_valid  (req0_valid),
        .req0_rd     (req0_rd),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_rd     (req1_rd),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .busy        (busy)
    );

    typedef struct {
        bit        rst;
        bit        iv;
        bit [4:0]  rs1, rs2, rd;
        bit        r0v;
        bit [4:0]  r0rd;
        bit [31:0] r0d;
        bit        r1v;
        bit [4:0]  r1rd;
        bit [31:0] r1d;
        bit        chk;     // check registered outputs
        bit        chkd;    // also check rf_waddr / rf_wdata
        bit        e_stall, e_rdy0, e_rdy1, e_we;
        bit [4:0]  e_waddr;
        bit [31:0] e_wdata;
        bit [31:0] e_busy;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(int r, int iv, int rs1, int rs2, int rd,
                                int r0v, int r0rd, longint r0d,
                                int r1v, int r1rd, longint r1d,
                                int chk, int chkd, int st, int y0, int y1,
                                int we, int wa, longint wd, longint bz);
        vec_t v;
        v.rst = r[0];   v.iv = iv[0];
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
        v.r0v = r0v[0]; v.r0rd = 5'(r0rd); v.r0d = 32'(r0d);
        v.r1v = r1v[0]; v.r1rd = 5'(r1rd); v.r1d = 32'(r1d);
        v.chk = chk[0]; v.chkd = chkd[0];
        v.e_stall = st[0]; v.e_rdy0 = y0[0]; v.e_rdy1 = y1[0]; v.e_we = we[0];
        v.e_waddr = 5'(wa); v.e_wdata = 32'(wd); v.e_busy = 32'(bz);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit iv, input bit [4:0] rs1, input bit [4:0] rs2,
                         input bit [4:0] rd, input bit r0v, input bit [4:0] r0rd,
                         input bit [31:0] r0d, input bit r1v, input bit [4:0] r1rd,
                         input bit [31:0] r1d);
        rst = r; issue_valid = iv; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
        req0_valid = r0v; req0_rd = r0rd; req0_data = r0d;
        req1_valid = r1v; req1_rd = r1rd; req1_data = r1d;
    endtask

    // Behavioural model state for the randomized run
    bit [31:0] m_busy;
    bit        m_we;
    bit [4:0]  m_waddr;
    bit [31:0] m_wdata;
    int        m_last;          // requester that won the last contest
    bit        p0v, p1v;
    bit [4:0]  p0rd, p1rd;
    bit [31:0] p0d, p1d;

    initial begin
        int exp_win[4];
        bit r;
        bit iv;
        bit [4:0] rs1, rs2, rd;
        int w;
        bit e_stall;
        bit [4:0] wrd;
        bit [31:0] wd;

        //          rst iv rs1 rs2 rd  r0v r0rd r0d         r1v r1rd r1d      chk chkd st y0 y1 we wa wd           busy
        tbl[0]  = mk(1, 0, 0, 0, 0,    1, 3, 'h11,          1, 5, 'h22,      0, 0,  0, 0, 0, 0, 0, 0,           0);
        tbl[1]  = mk(1, 0, 0, 0, 0,    1, 3, 'h11,          1, 5, 'h22,      1, 1,  0, 0, 0, 0, 0, 0,           0);
        tbl[2]  = mk(0, 0, 0, 0, 0,    1, 7, 'hA5A5A5A5,    0, 0, 0,         1, 1,  0, 1, 0, 0, 0, 0,           0);
        tbl[3]  = mk(0, 0, 0, 0, 0,    0, 0, 0,             0, 0, 0,         1, 1,  0, 0, 0, 1, 7, 'hA5A5A5A5,  0);
        tbl[4]  = mk(0, 0, 0, 0, 0,    1, 3, 'h33,          1, 5, 'h55,      1, 0,  0, 0, 1, 0, 0, 0,           0);
        tbl[5]  = mk(0, 0, 0, 0, 0,    1, 3, 'h33,          0, 0, 0,         1, 1,  0, 1, 0, 1, 5, 'h55,        0);
        tbl[6]  = mk(0, 0, 0, 0, 0,    0, 0, 0,             0, 0, 0,         1, 1,  0, 0, 0, 1, 3, 'h33,        0);
        tbl[7]  = mk(0, 1, 0, 0, 7,    0, 0, 0,             0, 0, 0,         1, 0,  0, 0, 0, 0, 0, 0,           0);
        tbl[8]  = mk(0, 1, 0, 7, 0,    0, 0, 0,             0, 0, 0,         1, 0,  1, 0, 0, 0, 0, 0,           'h80);
        tbl[9]  = mk(0, 1, 0, 7, 0,    0, 0, 0,             1, 7, 'hBEEF,    1, 0,  1, 0, 1, 0, 0, 0,           'h80);
        tbl[10] = mk(0, 1, 0, 7, 0,    0, 0, 0,             0, 0, 0,         1, 1,  0, 0, 0, 1, 7, 'hBEEF,      0);
        tbl[11] = mk(0, 1, 0, 0, 0,    1, 0, 'h1234,        0, 0, 0,         1, 0,  0, 1, 0, 0, 0, 0,           0);
        tbl[12] = mk(0, 0, 0, 0, 0,    0, 0, 0,             0, 0, 0,         1, 0,  0, 0, 0, 0, 0, 0,           0);
        tbl[13] = mk(0, 1, 0, 0, 9,    1, 9, 'h99,          0, 0, 0,         1, 0,  0, 1, 0, 0, 0, 0,           0);
        tbl[14] = mk(0, 0, 0, 0, 0,    0, 0, 0,             0, 0, 0,         1, 1,  0, 0, 0, 1, 9, 'h99,        'h200);
        tbl[15] = mk(0, 1, 9, 0, 0,    0, 0, 0,             1, 9, 'h1,       1, 0,  1, 0, 1, 0, 0, 0,           'h200);
        tbl[16] = mk(0, 1, 0, 0, 12,   0, 0, 0,             0, 0, 0,         1, 1,  0, 0, 0, 1, 9, 'h1,         0);
        tbl[17] = mk(1, 0, 0, 0, 0,    1, 4, 'h4,           0, 0, 0,         1, 0,  0, 0, 0, 0, 0, 0,           'h1000);
        tbl[18] = mk(0, 0, 0, 0, 0,    0, 0, 0,             0, 0, 0,         1, 1,  0, 0, 0, 0, 0, 0,           0);

        // Directed table: inputs change on the falling edge, outputs are
        // sampled 1 time unit later, well clear of the rising edge.
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].iv, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
                  tbl[i].r0v, tbl[i].r0rd, tbl[i].r0d, tbl[i].r1v, tbl[i].r1rd, tbl[i].r1d);
            #1;
            chk($sformatf("tbl%0d_stall", i), 32'(issue_stall), 32'(tbl[i].e_stall));
            chk($sformatf("tbl%0d_rdy0", i),  32'(req0_ready),  32'(tbl[i].e_rdy0));
            chk($sformatf("tbl%0d_rdy1", i),  32'(req1_ready),  32'(tbl[i].e_rdy1));
            if (tbl[i].chk) begin
                chk($sformatf("tbl%0d_we", i),   32'(rf_we), 32'(tbl[i].e_we));
                chk($sformatf("tbl%0d_busy", i), busy,       tbl[i].e_busy);
            end
            if (tbl[i].chkd) begin
                chk($sformatf("tbl%0d_waddr", i), 32'(rf_waddr), 32'(tbl[i].e_waddr));
                chk($sformatf("tbl%0d_wdata", i), rf_wdata,      tbl[i].e_wdata);
            end
        end

        // Continuous contention straight after a reset: both requesters
        // present a fresh request as soon as the previous one is granted.
        exp_win = RR ? '{1, 0, 1, 0} : '{1, 1, 1, 1};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 1, 10, 32'h100 + 32'(k), 1, 11, 32'h200 + 32'(k));
            #1;
            chk($sformatf("rr%0d_rdy1", k), 32'(req1_ready), 32'(exp_win[k] == 1));
            chk($sformatf("rr%0d_rdy0", k), 32'(req0_ready), 32'(exp_win[k] == 0));
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rr_last_we",    32'(rf_we),    32'd1);
        chk("rr_last_waddr", 32'(rf_waddr), (exp_win[3] == 1) ? 32'd11 : 32'd10);

        // Randomized run against the behavioural model
        m_busy = '0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_last = 0;
        p0v = 1'b0; p1v = 1'b0; p0rd = '0; p1rd = '0; p0d = '0; p1d = '0;
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            r = ($urandom_range(0, 49) == 0);
            if (!p0v && $urandom_range(0, 2) == 0) begin
                p0v = 1'b1; p0rd = 5'($urandom_range(0, 7)); p0d = $urandom;
            end
            if (!p1v && $urandom_range(0, 2) == 0) begin
                p1v = 1'b1; p1rd = 5'($urandom_range(0, 7)); p1d = $urandom;
            end
            iv  = 1'($urandom_range(0, 1));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 7));
            drive(r, iv, rs1, rs2, rd, p0v, p0rd, p0d, p1v, p1rd, p1d);

            // Expected combinational behaviour for this cycle
            e_stall = iv && ((rs1 != 0 && m_busy[rs1]) || (rs2 != 0 && m_busy[rs2]) ||
                             (rd != 0 && m_busy[rd]));
            if (r)              w = -1;
            else if (p0v && p1v) w = (RR && m_last == 1) ? 0 : 1;
            else if (p1v)       w = 1;
            else if (p0v)       w = 0;
            else                w = -1;

            #1;
            chk("rnd_stall", 32'(issue_stall), 32'(e_stall));
            chk("rnd_rdy0",  32'(req0_ready),  32'(w == 0));
            chk("rnd_rdy1",  32'(req1_ready),  32'(w == 1));
            chk("rnd_we",    32'(rf_we),       32'(m_we));
            chk("rnd_busy",  busy,             m_busy);
            if (m_we) begin
                chk("rnd_waddr", 32'(rf_waddr), 32'(m_waddr));
                chk("rnd_wdata", rf_wdata,      m_wdata);
            end

            // Model state after the coming rising edge
            if (r) begin
                m_busy = '0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_last = 0;
                p0v = 1'b0; p1v = 1'b0;
            end else begin
                wrd = (w == 1) ? p1rd : p0rd;
                wd  = (w == 1) ? p1d  : p0d;
                if (w >= 0) m_busy[wrd] = 1'b0;
                if (iv && !e_stall && rd != 0) m_busy[rd] = 1'b1;
                m_busy[0] = 1'b0;
                m_we = (w >= 0) && (wrd != 0);
                if (m_we) begin
                    m_waddr = wrd;
                    m_wdata = wd;
                end
                if (p0v && p1v) m_last = w;
                if (w == 0) p0v = 1'b0;
                if (w == 1) p1v = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
